ifm_skew_feeder: RTL and testbench

//  Row-side feeder for the 16x16 rate-coded uGEMM systolic array. Accepts one

---
 rtl/ifm_skew_feeder_if.sv | 26 ++
 rtl/ifm_skew_feeder.sv | 121 ++++++++++++
 tb/tb_ifm_skew_feeder.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifm_skew_feeder_if.sv
// Input-vector valid/ready bundle for the row-side skew feeder.
// The producer drives the vector and hold length; the feeder answers with ready.
interface ifm_skew_feeder_if #(
    parameter int HEIGHT  = 16,
    parameter int IWIDTH  = 16,
    parameter int CYCLE_W = 8
);
    logic                          in_valid;
    logic                          in_ready;
    logic [CYCLE_W-1:0]            cfg_cycles;
    logic [HEIGHT-1:0][IWIDTH-1:0] in_ifm;

    modport master (
        output in_valid,
        output cfg_cycles,
        output in_ifm,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  cfg_cycles,
        input  in_ifm,
        output in_ready
    );
endinterface

// File: rtl/ifm_skew_feeder.sv
// Row-side feeder: holds one ifm vector for N MAC cycles and skews
// en/clr/done/ifm so row h lags row 0 by exactly h cycles.
module ifm_skew_feeder #(
    parameter int HEIGHT  = 16,
    parameter int IWIDTH  = 16,
    parameter int CYCLE_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    ifm_skew_feeder_if.slave              in_if,
    output logic [HEIGHT-1:0][IWIDTH-1:0] ifm,
    output logic [HEIGHT-1:0]             en_i,
    output logic [HEIGHT-1:0]             clr_i,
    output logic [HEIGHT-1:0]             mac_done,
    output logic                          busy
);
    typedef enum logic {IDLE, HOLD} state_e;

    state_e                        state_q, state_d;
    logic [CYCLE_W-1:0]            rem_q, rem_d;
    logic [CYCLE_W-1:0]            n_eff;
    logic                          start_q;
    logic [HEIGHT-1:0][IWIDTH-1:0] word_q;
    logic                          ready;
    logic                          accept;
    logic                          en0, clr0, done0;
    logic [HEIGHT-1:0]             row_busy;

    assign ready          = (rem_q <= CYCLE_W'(1));
    assign in_if.in_ready = ready;
    assign accept         = in_if.in_valid & ready;
    assign n_eff          = (in_if.cfg_cycles == '0) ? CYCLE_W'(1)
                                                     : in_if.cfg_cycles;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = HOLD;
                    rem_d   = n_eff;
                end
            end
            HOLD: begin
                rem_d = rem_q - CYCLE_W'(1);
                if (accept) begin
                    rem_d = n_eff;
                end else if (rem_q == CYCLE_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            start_q <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            start_q <= accept;
            if (accept) begin
                word_q <= in_if.in_ifm;
            end
        end
    end

    // Row 0 is the undelayed schedule; every other row taps a private delay line.
    assign en0   = (state_q == HOLD);
    assign clr0  = start_q;
    assign done0 = (state_q == HOLD) && (rem_q == CYCLE_W'(1));

    assign en_i[0]     = en0;
    assign clr_i[0]    = clr0;
    assign mac_done[0] = done0;
    assign ifm[0]      = word_q[0];
    assign row_busy[0] = en0;

    for (genvar h = 1; h < HEIGHT; h++) begin : g_row
        logic [h-1:0]             en_q;
        logic [h-1:0]             clr_q;
        logic [h-1:0]             done_q;
        logic [h-1:0][IWIDTH-1:0] wd_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                en_q   <= '0;
                clr_q  <= '0;
                done_q <= '0;
                wd_q   <= '0;
            end else begin
                en_q[0]   <= en0;
                clr_q[0]  <= clr0;
                done_q[0] <= done0;
                wd_q[0]   <= word_q[h];
                for (int k = 1; k < h; k++) begin
                    en_q[k]   <= en_q[k-1];
                    clr_q[k]  <= clr_q[k-1];
                    done_q[k] <= done_q[k-1];
                    wd_q[k]   <= wd_q[k-1];
                end
            end
        end

        assign en_i[h]     = en_q[h-1];
        assign clr_i[h]    = clr_q[h-1];
        assign mac_done[h] = done_q[h-1];
        assign ifm[h]      = wd_q[h-1];
        assign row_busy[h] = |en_q;
    end

    assign busy = |row_busy;
endmodule

// File: tb/tb_ifm_skew_feeder.sv
// Self-checking bench for ifm_skew_feeder: a vector-history reference model
// derives every row's expected schedule from accept times and hold lengths.
module tb_ifm_skew_feeder;
    localparam int H  = 16;
    localparam int W  = 16;
    localparam int CW = 8;
    localparam int OW = 2 + 3*H + H*W;

    typedef logic [OW-1:0] obs_t;
    typedef struct {
        int                  t;
        int                  n;
        logic [H-1:0][W-1:0] w;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [H-1:0][W-1:0] ifm;
    logic [H-1:0]        en_i, clr_i, mac_done;
    logic                busy;

    ifm_skew_feeder_if #(.HEIGHT(H), .IWIDTH(W), .CYCLE_W(CW)) bus ();

    ifm_skew_feeder #(.HEIGHT(H), .IWIDTH(W), .CYCLE_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_if    (bus),
        .ifm      (ifm),
        .en_i     (en_i),
        .clr_i    (clr_i),
        .mac_done (mac_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    vec_t hist[$];
    int   acc_q[$];
    bit   acc_now;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    obs_t e, o;

    // Expected outputs in cycle c from the list of vectors accepted since reset.
    function automatic obs_t model_out(int c);
        logic [H-1:0]        en  = '0;
        logic [H-1:0]        clr = '0;
        logic [H-1:0]        dn  = '0;
        logic [H-1:0][W-1:0] f   = '0;
        logic                bz  = 1'b0;
        int                  rem = 0;
        foreach (hist[i]) begin
            int t = hist[i].t;
            int n = hist[i].n;
            if (c >= t + 1 && c <= t + n) rem = t + n + 1 - c;
            if (c >= t + 1 && c <= t + n + H - 1) bz = 1'b1;
            for (int h = 0; h < H; h++) begin
                if (c >= t + 1 + h) begin
                    f[h]   = hist[i].w[h];
                    en[h]  = (c <= t + n + h);
                    clr[h] = (c == t + 1 + h);
                    dn[h]  = (c == t + n + h);
                end
            end
        end
        return {(rem <= 1), bz, en, clr, dn, f};
    endfunction

    function automatic obs_t observe();
        return {bus.in_ready, busy, en_i, clr_i, mac_done, ifm};
    endfunction

    // Records this cycle's accept/reset in the model, then advances one clock.
    task automatic tick();
        obs_t m;
        m = model_out(cyc);
        acc_now = 1'b0;
        if (rst) begin
            hist.delete();
        end else if (bus.in_valid && m[OW-1]) begin
            vec_t v;
            v.t = cyc;
            v.n = (bus.cfg_cycles == '0) ? 1 : int'(bus.cfg_cycles);
            v.w = bus.in_ifm;
            hist.push_back(v);
            acc_q.push_back(cyc);
            acc_now = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rand_words();
        for (int h = 0; h < H; h++) bus.in_ifm[h] = W'($urandom);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'($urandom);
            rand_words();
            @(negedge clk);
            e = model_out(cyc);
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            checks++;
            if (en_i !== '0 || ifm !== '0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL reset_state cyc=%0d en=%h busy=%b rdy=%b", cyc, en_i, busy, bus.in_ready);
            end
            tick();
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_single();
        int t;
        acc_q.delete();
        bus.cfg_cycles = 8'd4;
        for (int h = 0; h < H; h++) bus.in_ifm[h] = W'(h + 1);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            e = model_out(cyc);
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL single cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            t = (acc_q.size() > 0) ? acc_q[0] : -100;
            if (cyc == t + 1) begin
                checks++;
                if (ifm[0] !== 16'd1 || clr_i[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL single_row0 got ifm=%0d clr=%b exp 1/1", ifm[0], clr_i[0]);
                end
            end
            if (cyc == t + 19) begin
                checks++;
                if (ifm[15] !== 16'd16 || mac_done[15] !== 1'b1) begin
                    failures++;
                    $display("FAIL single_row15 got ifm=%0d done=%b exp 16/1", ifm[15], mac_done[15]);
                end
            end
            if (cyc == t + 20) begin
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL single_busy got %b exp 0", busy);
                end
            end
            tick();
            if (acc_now) begin
                bus.in_valid = 1'b0;
                bus.cfg_cycles = 8'd7;
                rand_words();
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [H-1:0][W-1:0] a, b;
        int t;
        acc_q.delete();
        bus.cfg_cycles = 8'd2;
        rand_words();
        a = bus.in_ifm;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            e = model_out(cyc);
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            t = (acc_q.size() > 0) ? acc_q[0] : -100;
            if (cyc == t + 6 || cyc == t + 8) begin
                checks++;
                if (ifm[5] !== ((cyc == t + 6) ? a[5] : b[5])) begin
                    failures++;
                    $display("FAIL b2b_row5 cyc=%0d got=%h", cyc, ifm[5]);
                end
            end
            tick();
            if (acc_now && acc_q.size() == 1) begin
                rand_words();
                b = bus.in_ifm;
            end else if (acc_now) begin
                bus.in_valid = 1'b0;
            end
        end
        checks++;
        if (acc_q.size() < 2 || acc_q[1] - acc_q[0] != 2) begin
            failures++;
            $display("FAIL b2b_gap got n=%0d exp gap 2", acc_q.size());
        end
    endtask

    task automatic test_short();
        acc_q.delete();
        bus.cfg_cycles = 8'd0;
        rand_words();
        bus.in_valid = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            e = model_out(cyc);
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL short cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            checks++;
            if (bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL short_ready cyc=%0d got 0 exp 1", cyc);
            end
            tick();
            if (acc_now) begin
                rand_words();
                bus.cfg_cycles = (acc_q.size() == 1) ? 8'd1 : 8'd0;
                if (acc_q.size() == 3) bus.in_valid = 1'b0;
            end
        end
        checks++;
        if (acc_q.size() != 3 || acc_q[2] - acc_q[0] != 2) begin
            failures++;
            $display("FAIL short_accepts got n=%0d exp 3 consecutive", acc_q.size());
        end
    endtask

    task automatic test_backpressure();
        acc_q.delete();
        bus.cfg_cycles = 8'd8;
        rand_words();
        bus.in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            e = model_out(cyc);
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL bp cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            tick();
            if (acc_now) rand_words();
            if (acc_now && acc_q.size() == 2) bus.in_valid = 1'b0;
        end
        checks++;
        if (acc_q.size() < 2 || acc_q[1] - acc_q[0] != 8) begin
            failures++;
            $display("FAIL bp_gap got n=%0d exp gap 8", acc_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int t;
        acc_q.delete();
        bus.cfg_cycles = 8'd8;
        rand_words();
        bus.in_valid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            e = model_out(cyc);
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL rst_mid cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            t = (acc_q.size() > 0) ? acc_q[0] : 1000;
            if (cyc == t + 6) begin
                checks++;
                if (en_i !== '0 || ifm !== '0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL rst_mid_clear got en=%h busy=%b rdy=%b", en_i, busy, bus.in_ready);
                end
            end
            if (cyc > t + 6) begin
                checks++;
                if ((en_i | clr_i | mac_done) !== '0) begin
                    failures++;
                    $display("FAIL rst_mid_residue cyc=%0d en=%h clr=%h done=%h", cyc, en_i, clr_i, mac_done);
                end
            end
            tick();
            if (acc_now) bus.in_valid = 1'b0;
            rst = (acc_q.size() > 0 && cyc == acc_q[0] + 5);
        end
        rst = 1'b0;
    endtask

    task automatic test_rst_accept();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.cfg_cycles = 8'd3;
        rand_words();
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            e = model_out(cyc);
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL rst_acc cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            if (k > 0) begin
                checks++;
                if (en_i !== '0) begin
                    failures++;
                    $display("FAIL rst_acc_en cyc=%0d got=%h exp 0", cyc, en_i);
                end
            end
            tick();
            rst = 1'b0;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            e = model_out(cyc);
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            tick();
            bus.in_valid = (k < 470) && ($urandom_range(0, 2) != 0);
            bus.cfg_cycles = CW'($urandom_range(0, 5));
            rand_words();
            rst = ($urandom_range(0, 79) == 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.cfg_cycles = '0;
        bus.in_ifm = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_short();
        test_backpressure();
        test_reset_mid();
        test_rst_accept();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
